// File: rtl/sa_axis_pkg.sv
// rtl/sa_axis_pkg.sv - shared state encoding and width helpers for the systolic stream controller
package sa_axis_pkg;

    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        SEND  = 3'd4
    } sa_state_e;

    function automatic int s_w(input int n, input int in_w);
        return 2 * n * in_w;
    endfunction

    function automatic int r_w(input int n, input int acc_w);
        return n * n * acc_w;
    endfunction

    function automatic int beats(input int res_w, input int m_w);
        return res_w / m_w;
    endfunction

endpackage

// File: rtl/sa_axis_stream_ctrl_if.sv
// rtl/sa_axis_stream_ctrl_if.sv - stream, array and status bundle of the systolic stream controller
interface sa_axis_stream_ctrl_if #(
    parameter int N     = 3,
    parameter int IN_W  = 8,
    parameter int ACC_W = 16,
    parameter int M_W   = 48
);
    logic                    s_axis_valid;
    logic [2*N*IN_W-1:0]     s_axis_data;
    logic                    s_axis_last;
    logic                    s_axis_ready;
    logic                    m_axis_valid;
    logic [M_W-1:0]          m_axis_data;
    logic                    m_axis_last;
    logic                    m_axis_ready;
    logic [N*IN_W-1:0]       arr_a;
    logic [N*IN_W-1:0]       arr_b;
    logic                    arr_en;
    logic                    arr_clear;
    logic [N*N*ACC_W-1:0]    arr_c;
    logic                    arr_c_valid;
    logic                    busy;
    logic                    err_overflow;

    modport slave (
        input  s_axis_valid, s_axis_data, s_axis_last, m_axis_ready, arr_c, arr_c_valid,
        output s_axis_ready, m_axis_valid, m_axis_data, m_axis_last,
               arr_a, arr_b, arr_en, arr_clear, busy, err_overflow
    );

    modport master (
        output s_axis_valid, s_axis_data, s_axis_last, m_axis_ready, arr_c, arr_c_valid,
        input  s_axis_ready, m_axis_valid, m_axis_data, m_axis_last,
               arr_a, arr_b, arr_en, arr_clear, busy, err_overflow
    );
endinterface

// File: rtl/sa_sync_fifo_fwft.sv
// rtl/sa_sync_fifo_fwft.sv - single-clock first-word-fall-through FIFO holding one job
module sa_sync_fifo_fwft #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               wdata,
    output logic [WIDTH-1:0]               rdata,
    output logic                           empty,
    output logic                           full,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty))
        else $error("fifo pop while empty");
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full))
        else $error("fifo push while full");

endmodule

// File: rtl/sa_axis_stream_ctrl.sv
// rtl/sa_axis_stream_ctrl.sv - buffers one matmul job, replays it into the array and streams the result out
module sa_axis_stream_ctrl
    import sa_axis_pkg::*;
#(
    parameter int N     = 3,
    parameter int IN_W  = 8,
    parameter int ACC_W = 16,
    parameter int DEPTH = 16,
    parameter int M_W   = 48
) (
    input  logic                  axi_clk,
    input  logic                  axi_rst_n,
    sa_axis_stream_ctrl_if.slave  bus
);
    localparam int S_W   = s_w(N, IN_W);
    localparam int R_W   = r_w(N, ACC_W);
    localparam int BEATS = beats(R_W, M_W);
    localparam int AV_W  = N * IN_W;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [2:0] S_LOAD  = LOAD;
    localparam logic [2:0] S_CLEAR = CLEAR;
    localparam logic [2:0] S_RUN   = RUN;
    localparam logic [2:0] S_DRAIN = DRAIN;
    localparam logic [2:0] S_SEND  = SEND;

    generate
        if ((R_W % M_W) != 0) begin : g_bad_mw
            $error("M_W must divide N*N*ACC_W");
        end
        if (DEPTH < 1) begin : g_bad_depth
            $error("DEPTH must be at least 1");
        end
    endgenerate

    logic [2:0]      state_q, state_d;
    logic [CW-1:0]   k_q, k_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [R_W-1:0]  result_q, result_d;
    logic [M_W-1:0]  m_data_q, m_data_d;
    logic            m_valid_q, m_valid_d;
    logic            m_last_q, m_last_d;
    logic            arr_en_q, arr_en_d;
    logic            arr_clear_q, arr_clear_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;

    logic            s_hs;
    logic            fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [S_W-1:0]  fifo_rdata;
    logic [CW-1:0]   fifo_count;

    assign s_hs      = (state_q == S_LOAD) && bus.s_axis_valid;
    assign fifo_push = s_hs;
    assign fifo_pop  = (state_q == S_RUN);

    sa_sync_fifo_fwft #(
        .WIDTH (S_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (axi_clk),
        .rst_n (axi_rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (bus.s_axis_data),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        idx_d    = idx_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            S_LOAD: begin
                if (s_hs) begin
                    k_d = k_q + CW'(1);
                    if (k_q == '0) err_d = 1'b0;
                    if (bus.s_axis_last) begin
                        state_d = S_CLEAR;
                    end else if (k_q == CW'(DEPTH - 1)) begin
                        // A full FIFO closes the job rather than back-pressuring the source.
                        err_d   = 1'b1;
                        state_d = S_CLEAR;
                    end
                end
            end
            S_CLEAR: state_d = S_RUN;
            S_RUN: begin
                if (fifo_count == CW'(1)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (bus.arr_c_valid) begin
                    result_d = bus.arr_c;
                    idx_d    = '0;
                    state_d  = S_SEND;
                end
            end
            S_SEND: begin
                if (bus.m_axis_ready) begin
                    if (idx_q == IW'(BEATS - 1)) begin
                        state_d = S_LOAD;
                        k_d     = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase

        // Registered outputs are derived from the next state so they line up with it.
        arr_clear_d = (state_d == S_CLEAR);
        arr_en_d    = (state_d == S_RUN) || (state_d == S_DRAIN);
        busy_d      = (state_d != S_LOAD);
        m_valid_d   = (state_d == S_SEND);
        m_last_d    = m_valid_d && (idx_d == IW'(BEATS - 1));
        m_data_d    = '0;
        if (m_valid_d) begin
            for (int b = 0; b < BEATS; b++) begin
                if (idx_d == IW'(b)) m_data_d = result_d[b*M_W +: M_W];
            end
        end
    end

    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            state_q     <= S_LOAD;
            k_q         <= '0;
            idx_q       <= '0;
            result_q    <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            arr_en_q    <= 1'b0;
            arr_clear_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            idx_q       <= idx_d;
            result_q    <= result_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            arr_en_q    <= arr_en_d;
            arr_clear_q <= arr_clear_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign bus.s_axis_ready = (state_q == S_LOAD);
    assign bus.m_axis_valid = m_valid_q;
    assign bus.m_axis_data  = m_data_q;
    assign bus.m_axis_last  = m_last_q;
    assign bus.arr_en       = arr_en_q;
    assign bus.arr_clear    = arr_clear_q;
    assign bus.busy         = busy_q;
    assign bus.err_overflow = err_q;
    assign bus.arr_a        = (state_q == S_RUN) ? fifo_rdata[AV_W-1:0]    : '0;
    assign bus.arr_b        = (state_q == S_RUN) ? fifo_rdata[S_W-1:AV_W]  : '0;

    a_load_never_full: assert property (@(posedge axi_clk) disable iff (!axi_rst_n)
        !(fifo_push && fifo_full)) else $error("beat offered to a full FIFO");
    a_run_has_data: assert property (@(posedge axi_clk) disable iff (!axi_rst_n)
        !(fifo_pop && fifo_empty)) else $error("RUN with empty FIFO");

endmodule

// File: tb/tb_sa_axis_stream_ctrl.sv
// tb/tb_sa_axis_stream_ctrl.sv - scoreboard bench for sa_axis_stream_ctrl with an ideal MAC array model
module tb_sa_axis_stream_ctrl;
    localparam int N     = 3;
    localparam int IN_W  = 8;
    localparam int ACC_W = 16;
    localparam int DEPTH = 16;
    localparam int M_W   = 48;
    localparam int R_W   = N * N * ACC_W;
    localparam int BEATS = R_W / M_W;
    localparam int AV_W  = N * IN_W;

    typedef struct {
        logic [M_W-1:0] data;
        logic           last;
    } exp_t;

    logic axi_clk = 1'b0;
    logic axi_rst_n;
    always #5 axi_clk = ~axi_clk;

    sa_axis_stream_ctrl_if #(.N(N), .IN_W(IN_W), .ACC_W(ACC_W), .M_W(M_W)) bus ();

    sa_axis_stream_ctrl #(
        .N(N), .IN_W(IN_W), .ACC_W(ACC_W), .DEPTH(DEPTH), .M_W(M_W)
    ) u_dut (
        .axi_clk   (axi_clk),
        .axi_rst_n (axi_rst_n),
        .bus       (bus.slave)
    );

    exp_t            sb_q[$];
    int              n_cmp = 0;
    int              n_mis = 0;
    int              model_k = 0;
    logic [AV_W-1:0] ja [DEPTH];
    logic [AV_W-1:0] jb [DEPTH];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Ideal outer-product MAC array; result appears after 2N-1 drain cycles.
    logic [ACC_W-1:0] macc [N][N];
    int               mcnt;
    always @(negedge axi_clk) begin
        if (!axi_rst_n || bus.arr_clear) begin
            for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) macc[i][j] = '0;
            mcnt = 0;
            bus.arr_c_valid = 1'b0;
        end else begin
            if (bus.arr_en) begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        macc[i][j] = macc[i][j] + ACC_W'(32'(bus.arr_a[i*IN_W +: IN_W]) *
                                                         32'(bus.arr_b[j*IN_W +: IN_W]));
                mcnt++;
            end
            bus.arr_c_valid = bus.arr_en && (mcnt >= model_k + 2*N - 1);
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                bus.arr_c[(i*N+j)*ACC_W +: ACC_W] = macc[i][j];
    end

    // Output monitor: scoreboard pop, hold stability under stall, ready turnaround.
    logic            stall_pend = 1'b0;
    logic            last_done  = 1'b0;
    logic [M_W-1:0]  held_data;
    logic            held_last;
    always @(negedge axi_clk) begin
        if (!axi_rst_n) begin
            stall_pend = 1'b0;
            last_done  = 1'b0;
        end else begin
            if (stall_pend) begin
                check("stall_data_hold", 64'(bus.m_axis_data), 64'(held_data));
                check("stall_last_hold", 64'(bus.m_axis_last), 64'(held_last));
                stall_pend = 1'b0;
            end
            if (last_done) begin
                check("s_ready_after_last", 64'(bus.s_axis_ready), 64'd1);
                check("m_valid_after_last", 64'(bus.m_axis_valid), 64'd0);
                last_done = 1'b0;
            end
            if (bus.m_axis_valid) begin
                check("s_ready_low_in_send", 64'(bus.s_axis_ready), 64'd0);
                if (bus.m_axis_ready) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_beat", 64'(bus.m_axis_data), 64'd0);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check("m_data", 64'(bus.m_axis_data), 64'(e.data));
                        check("m_last", 64'(bus.m_axis_last), 64'(e.last));
                        if (e.last) last_done = 1'b1;
                    end
                end else begin
                    stall_pend = 1'b1;
                    held_data  = bus.m_axis_data;
                    held_last  = bus.m_axis_last;
                end
            end
        end
    end

    task automatic fill_identity();
        for (int b = 0; b < N; b++) begin
            ja[b] = '0;
            ja[b][b*IN_W +: IN_W] = IN_W'(1);
            for (int j = 0; j < N; j++) jb[b][j*IN_W +: IN_W] = IN_W'(b*N + j + 1);
        end
    endtask

    task automatic fill_random(input int k);
        for (int b = 0; b < k; b++) begin
            for (int i = 0; i < N; i++) begin
                ja[b][i*IN_W +: IN_W] = IN_W'($urandom_range(0, 255));
                jb[b][i*IN_W +: IN_W] = IN_W'($urandom_range(0, 255));
            end
        end
    endtask

    task automatic send_job(input int k, input bit gaps, input bit use_last);
        int               kk;
        bit               exp_ovf;
        int               w;
        logic [ACC_W-1:0] acc [N][N];
        logic [R_W-1:0]   res;
        exp_t             e;
        kk      = (k > DEPTH) ? DEPTH : k;
        exp_ovf = (kk == DEPTH) && (!use_last || k > DEPTH);
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) acc[i][j] = '0;
        for (int b = 0; b < kk; b++)
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    acc[i][j] = acc[i][j] + ACC_W'(32'(ja[b][i*IN_W +: IN_W]) *
                                                   32'(jb[b][j*IN_W +: IN_W]));
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                res[(i*N+j)*ACC_W +: ACC_W] = acc[i][j];
        for (int b = 0; b < BEATS; b++) begin
            e.data = res[b*M_W +: M_W];
            e.last = (b == BEATS - 1);
            sb_q.push_back(e);
        end
        model_k = kk;
        @(posedge axi_clk); #1;
        for (int b = 0; b < kk; b++) begin
            bus.s_axis_valid = 1'b1;
            bus.s_axis_data  = {jb[b], ja[b]};
            bus.s_axis_last  = use_last && (b == kk - 1);
            w = 0;
            @(negedge axi_clk);
            while (!bus.s_axis_ready && w < 1000) begin
                @(negedge axi_clk);
                w++;
            end
            if (w >= 1000) check("s_ready_timeout", 64'd0, 64'd1);
            @(posedge axi_clk); #1;
            bus.s_axis_valid = 1'b0;
            bus.s_axis_last  = 1'b0;
            if (b == 0) check("err_first_beat", 64'(bus.err_overflow), (kk == 1) ? 64'(exp_ovf) : 64'd0);
            if (gaps && b < kk - 1) begin
                @(posedge axi_clk); #1;
            end
        end
        check("clear_after_last", 64'(bus.arr_clear), 64'd1);
        check("en_low_in_clear", 64'(bus.arr_en), 64'd0);
        check("s_ready_low_clear", 64'(bus.s_axis_ready), 64'd0);
        check("busy_in_clear", 64'(bus.busy), 64'd1);
        check("err_overflow", 64'(bus.err_overflow), 64'(exp_ovf));
        @(posedge axi_clk); #1;
        check("clear_one_cycle", 64'(bus.arr_clear), 64'd0);
        check("first_run_en", 64'(bus.arr_en), 64'd1);
        check("first_run_a", 64'(bus.arr_a), 64'(ja[0]));
        check("first_run_b", 64'(bus.arr_b), 64'(jb[0]));
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < 2000) begin
            @(posedge axi_clk);
            w++;
        end
        check("sb_drain", 64'(sb_q.size()), 64'd0);
        repeat (2) @(posedge axi_clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        axi_rst_n         = 1'b1;
        bus.s_axis_valid  = 1'b0;
        bus.s_axis_data   = '0;
        bus.s_axis_last   = 1'b0;
        bus.m_axis_ready  = 1'b1;
        #2 axi_rst_n = 1'b0;
        repeat (3) @(posedge axi_clk);
        #1;
        check("rst_s_ready", 64'(bus.s_axis_ready), 64'd1);
        check("rst_m_valid", 64'(bus.m_axis_valid), 64'd0);
        check("rst_m_last", 64'(bus.m_axis_last), 64'd0);
        check("rst_m_data", 64'(bus.m_axis_data), 64'd0);
        check("rst_arr_en", 64'(bus.arr_en), 64'd0);
        check("rst_arr_clear", 64'(bus.arr_clear), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_err", 64'(bus.err_overflow), 64'd0);
        check("rst_arr_a", 64'(bus.arr_a), 64'd0);
        check("rst_arr_b", 64'(bus.arr_b), 64'd0);
        @(posedge axi_clk); #2 axi_rst_n = 1'b1;

        // Identity A: result equals B.
        fill_identity();
        send_job(3, 1'b0, 1'b1);
        wait_drain();

        // Stall after the first result beat.
        fill_random(3);
        send_job(3, 1'b0, 1'b1);
        w = 0;
        while (!bus.m_axis_valid && w < 200) begin
            @(posedge axi_clk); #1;
            w++;
        end
        check("stall_wait_valid", 64'(bus.m_axis_valid), 64'd1);
        @(posedge axi_clk); #1;
        bus.m_axis_ready = 1'b0;
        repeat (5) @(posedge axi_clk);
        #1 bus.m_axis_ready = 1'b1;
        wait_drain();

        // No tlast: truncated at DEPTH.
        fill_random(DEPTH);
        send_job(DEPTH, 1'b0, 1'b0);
        wait_drain();
        check("err_sticky", 64'(bus.err_overflow), 64'd1);

        // Gapped input, same data as the identity job.
        fill_identity();
        send_job(3, 1'b1, 1'b1);
        wait_drain();

        // Reset in DRAIN.
        fill_random(3);
        send_job(3, 1'b0, 1'b1);
        repeat (3) @(posedge axi_clk);
        #1;
        check("drain_en", 64'(bus.arr_en), 64'd1);
        check("drain_a_zero", 64'(bus.arr_a), 64'd0);
        axi_rst_n = 1'b0;
        #1;
        check("mid_rst_arr_en", 64'(bus.arr_en), 64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_m_valid", 64'(bus.m_axis_valid), 64'd0);
        check("mid_rst_m_data", 64'(bus.m_axis_data), 64'd0);
        check("mid_rst_arr_clear", 64'(bus.arr_clear), 64'd0);
        sb_q.delete();
        @(posedge axi_clk); #2 axi_rst_n = 1'b1;
        #1 check("post_rst_s_ready", 64'(bus.s_axis_ready), 64'd1);
        fill_random(2);
        send_job(2, 1'b0, 1'b1);
        wait_drain();

        // Back-to-back jobs, ready held high.
        fill_random(3);
        send_job(3, 1'b0, 1'b1);
        fill_random(3);
        send_job(3, 1'b0, 1'b1);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
